// File: rtl/dvp_pkg.sv
// Shared DVP pattern transmitter types: FSM states,
// pattern modes and the RGB565 colour-bar palette.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } dvp_state_e;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_FCNT  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  localparam logic [15:0] BAR_C0 = 16'hFFFF;
  localparam logic [15:0] BAR_C1 = 16'hFFE0;
  localparam logic [15:0] BAR_C2 = 16'h07FF;
  localparam logic [15:0] BAR_C3 = 16'h07E0;
  localparam logic [15:0] BAR_C4 = 16'hF81F;
  localparam logic [15:0] BAR_C5 = 16'hF800;
  localparam logic [15:0] BAR_C6 = 16'h001F;
  localparam logic [15:0] BAR_C7 = 16'h0000;

  function automatic logic [15:0] bar_color(
    input logic [2:0] idx
  );
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_C0;
      3'd1:    c = BAR_C1;
      3'd2:    c = BAR_C2;
      3'd3:    c = BAR_C3;
      3'd4:    c = BAR_C4;
      3'd5:    c = BAR_C5;
      3'd6:    c = BAR_C6;
      default: c = BAR_C7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pixel generator for the
// DVP pattern transmitter.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [7:0]    frame_cnt,
  input  logic [15:0]   solid_color,
  output logic [15:0]   pixel
);

  always_comb begin
    pixel = solid_color;
    unique case (mode)
      MODE_BARS: pixel = bar_color(3'(
        (32'(x) * 32'd8) / 32'(H_ACTIVE)));
      MODE_RAMP: pixel = 16'(x);
      MODE_FCNT: pixel = {frame_cnt, 8'(y)};
      default:   pixel = solid_color;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP camera-style test pattern source: frame timing FSM,
// byte serialisation of RGB565 pixels and frame counting.
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int H_BLANK     = 256,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_db,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int M1 = (VSYNC_LINES > V_BACK)
                    ? VSYNC_LINES : V_BACK;
  localparam int M2 = (V_ACTIVE > V_FRONT)
                    ? V_ACTIVE : V_FRONT;
  localparam int MAXL = (M1 > M2) ? M1 : M2;
  localparam int HW = $clog2(LINE + 1);
  localparam int VW = $clog2(MAXL + 1);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  dvp_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] line_q, line_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   color_q, color_d;
  logic [7:0]    fcnt_q, fcnt_d;

  logic          vs_q, vs_d;
  logic          href_q, href_d;
  logic [7:0]    db_q, db_d;
  logic          busy_q, busy_d;
  logic [7:0]    fout_q;

  logic [VW-1:0] lines_m1;
  logic          line_end;
  logic          last_line;
  logic          frame_go;
  logic [15:0]   pixel;

  assign line_end  = (hcnt_q == HW'(LINE - 1));
  assign last_line = (line_q == lines_m1);

  always_comb begin
    lines_m1 = '0;
    unique case (state_q)
      ST_VSYNC:  lines_m1 = VW'(VSYNC_LINES - 1);
      ST_VBACK:  lines_m1 = VW'(V_BACK - 1);
      ST_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
      ST_VFRONT: lines_m1 = VW'(V_FRONT - 1);
      default:   lines_m1 = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    line_d   = line_q;
    mode_d   = mode_q;
    color_d  = color_q;
    fcnt_d   = fcnt_q;
    frame_go = 1'b0;
    if (state_q == ST_IDLE) begin
      hcnt_d   = '0;
      line_d   = '0;
      frame_go = enable;
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
      if (line_end)
        line_d = last_line ? '0 : line_q + VW'(1);
      if (line_end && last_line) begin
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          default: begin
            fcnt_d   = fcnt_q + 8'd1;
            state_d  = ST_IDLE;
            frame_go = enable;
          end
        endcase
      end
    end
    // Mode and colour are frozen for the whole frame.
    if (frame_go) begin
      state_d = ST_VSYNC;
      mode_d  = mode;
      color_d = solid_color;
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_gen (
    .mode        (mode_q),
    .x           (XW'(hcnt_q >> 1)),
    .y           (YW'(line_q)),
    .frame_cnt   (fcnt_q),
    .solid_color (color_q),
    .pixel       (pixel)
  );

  always_comb begin
    vs_d   = (state_q == ST_VSYNC);
    busy_d = (state_q != ST_IDLE);
    href_d = (state_q == ST_ACTIVE) &&
             (hcnt_q < HW'(2 * H_ACTIVE));
    db_d   = '0;
    if (href_d)
      db_d = hcnt_q[0] ? pixel[7:0] : pixel[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      line_q  <= '0;
      mode_q  <= '0;
      color_q <= '0;
      fcnt_q  <= '0;
      vs_q    <= 1'b0;
      href_q  <= 1'b0;
      db_q    <= '0;
      busy_q  <= 1'b0;
      fout_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      line_q  <= line_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      fcnt_q  <= fcnt_d;
      vs_q    <= vs_d;
      href_q  <= href_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
      fout_q  <= fcnt_q;
    end
  end

  assign cmos_vsync = vs_q;
  assign cmos_href  = href_q;
  assign cmos_db    = db_q;
  assign frame_cnt  = fout_q;
  assign busy       = busy_q;

endmodule
